// File: rtl/text_console_pkg.sv
// Shared constants and types for the text console.
// Screen geometry matches the text-mode renderer: 80 x 30 cells of 8-bit
// glyph codes (640x480 with 8x16 glyphs). Also holds the control codes the
// console interprets, the FSM state type and a printable-range helper.
package text_console_pkg;

  localparam int ASCII_SIZE = 8;
  localparam int CHARS_HORZ = 80;
  localparam int CHARS_VERT = 30;
  localparam int ROW_W      = $clog2(CHARS_VERT);
  localparam int COL_W      = $clog2(CHARS_HORZ);

  localparam logic [ASCII_SIZE-1:0] ASCII_SPACE = 8'h20;
  localparam logic [ASCII_SIZE-1:0] ASCII_TILDE = 8'h7E;
  localparam logic [ASCII_SIZE-1:0] ASCII_LF    = 8'h0A;
  localparam logic [ASCII_SIZE-1:0] ASCII_CR    = 8'h0D;
  localparam logic [ASCII_SIZE-1:0] ASCII_BS    = 8'h08;

  typedef enum logic [1:0] {IDLE, SCROLL, CLRROW, CLEAR} consState_t;

  typedef logic [CHARS_HORZ-1:0][ASCII_SIZE-1:0] charRow_t;
  typedef logic [CHARS_VERT-1:0][CHARS_HORZ-1:0][ASCII_SIZE-1:0] charScreen_t;

  function automatic logic isPrintable(input logic [ASCII_SIZE-1:0] c);
    return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
  endfunction

endpackage

// File: rtl/text_console_if.sv
// Character stream into the console.
//  charIn    byte from the CPU/UART side
//  charValid charIn is valid this cycle
//  charReady console can take charIn this cycle
//  clearReq  one-cycle pulse: blank the screen and home the cursor
// master = byte producer, slave = console.
interface text_console_if;
  import text_console_pkg::*;

  logic [ASCII_SIZE-1:0] charIn;
  logic                  charValid;
  logic                  charReady;
  logic                  clearReq;

  modport master (output charIn, output charValid, output clearReq, input charReady);
  modport slave  (input charIn, input charValid, input clearReq, output charReady);

endinterface

// File: rtl/console_cursor.sv
// Cursor position tracking for the text console.
// Decodes the current byte and works out where the cursor goes and which
// cell (if any) the byte writes. The position registers only move on step.
//  clk_25M, reset  clock / synchronous active-high reset
//  home            force cursor to (0,0)
//  step            byte on charIn is being consumed this cycle
//  charIn          byte being decoded
//  cursorRow/Col   current position
//  overflow        this byte would move past the last row (scroll needed)
//  wrEn/Row/Col/Data  cell write this byte performs if consumed
module console_cursor
  import text_console_pkg::*;
(
  input  logic                  clk_25M,
  input  logic                  reset,
  input  logic                  home,
  input  logic                  step,
  input  logic [ASCII_SIZE-1:0] charIn,
  output logic [ROW_W-1:0]      cursorRow,
  output logic [COL_W-1:0]      cursorCol,
  output logic                  overflow,
  output logic                  wrEn,
  output logic [ROW_W-1:0]      wrRow,
  output logic [COL_W-1:0]      wrCol,
  output logic [ASCII_SIZE-1:0] wrData
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CHARS_VERT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(CHARS_HORZ - 1);

  logic [ROW_W-1:0] rowReg, rowNext;
  logic [COL_W-1:0] colReg, colNext;

  always_comb begin
    rowNext  = rowReg;
    colNext  = colReg;
    overflow = 1'b0;
    wrEn     = 1'b0;
    wrRow    = rowReg;
    wrCol    = colReg;
    wrData   = charIn;
    if (isPrintable(charIn)) begin
      wrEn = 1'b1;
      if (colReg == LAST_COL) begin
        colNext = '0;
        // On the last row the cursor stays put and the screen scrolls instead.
        if (rowReg == LAST_ROW) overflow = 1'b1;
        else                    rowNext = rowReg + ROW_W'(1);
      end else begin
        colNext = colReg + COL_W'(1);
      end
    end else if (charIn == ASCII_LF) begin
      colNext = '0;
      if (rowReg == LAST_ROW) overflow = 1'b1;
      else                    rowNext = rowReg + ROW_W'(1);
    end else if (charIn == ASCII_CR) begin
      colNext = '0;
    end else if (charIn == ASCII_BS) begin
      if (colReg != '0) begin
        colNext = colReg - COL_W'(1);
      end else if (rowReg != '0) begin
        rowNext = rowReg - ROW_W'(1);
        colNext = LAST_COL;
      end
      // Backspace always blanks the cell it lands on, even without a move.
      wrEn   = 1'b1;
      wrRow  = rowNext;
      wrCol  = colNext;
      wrData = ASCII_SPACE;
    end
  end

  always_ff @(posedge clk_25M) begin
    if (reset || home) begin
      rowReg <= '0;
      colReg <= '0;
    end else if (step) begin
      rowReg <= rowNext;
      colReg <= colNext;
    end
  end

  assign cursorRow = rowReg;
  assign cursorCol = colReg;

endmodule

// File: rtl/text_console.sv
// Text console: turns a byte stream into screen contents for the text-mode
// renderer. Writes printable bytes at the cursor, handles LF/CR/BS, wraps
// lines, and scrolls up one row when output runs off the bottom.
//  clk_25M     pixel clock, sole clock
//  reset       synchronous active-high reset
//  host        character stream (slave side)
//  charBuffer  registered screen contents, charBuffer[row][col]
//  cursorRow   current cursor row
//  cursorCol   current cursor column
module text_console
  import text_console_pkg::*;
(
  input  logic              clk_25M,
  input  logic              reset,
  text_console_if.slave     host,
  output charScreen_t       charBuffer,
  output logic [ROW_W-1:0]  cursorRow,
  output logic [COL_W-1:0]  cursorCol
);

  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(CHARS_VERT - 1);
  localparam logic [ROW_W-1:0] SCROLL_LAST = ROW_W'(CHARS_VERT - 2);
  localparam charRow_t         BLANK_ROW   = {CHARS_HORZ{ASCII_SPACE}};

  consState_t            stateReg, stateNext;
  logic [ROW_W-1:0]      rowIdxReg, rowIdxNext, rowIdxPlus1;
  logic                  clearPendingReg, clearPendingNext;
  logic                  accept, home, overflow, wrEn;
  logic [ROW_W-1:0]      wrRow;
  logic [COL_W-1:0]      wrCol;
  logic [ASCII_SIZE-1:0] wrData;

  assign host.charReady = (stateReg == IDLE) && !clearPendingReg && !host.clearReq;
  assign accept         = host.charValid && host.charReady;
  assign rowIdxPlus1    = rowIdxReg + ROW_W'(1);

  console_cursor cursor (
    .clk_25M   (clk_25M),
    .reset     (reset),
    .home      (home),
    .step      (accept),
    .charIn    (host.charIn),
    .cursorRow (cursorRow),
    .cursorCol (cursorCol),
    .overflow  (overflow),
    .wrEn      (wrEn),
    .wrRow     (wrRow),
    .wrCol     (wrCol),
    .wrData    (wrData)
  );

  always_comb begin
    stateNext        = stateReg;
    rowIdxNext       = rowIdxReg;
    clearPendingNext = clearPendingReg;
    home             = 1'b0;
    case (stateReg)
      IDLE: begin
        if (host.clearReq) begin
          stateNext  = CLEAR;
          rowIdxNext = '0;
          home       = 1'b1;
        end else if (accept && overflow) begin
          stateNext  = SCROLL;
          rowIdxNext = '0;
        end
      end
      SCROLL: begin
        if (host.clearReq) clearPendingNext = 1'b1;
        if (rowIdxReg == SCROLL_LAST) stateNext  = CLRROW;
        else                          rowIdxNext = rowIdxPlus1;
      end
      CLRROW: begin
        // A clear requested during the scroll takes the slot IDLE would have had.
        if (clearPendingReg || host.clearReq) begin
          stateNext        = CLEAR;
          rowIdxNext       = '0;
          clearPendingNext = 1'b0;
          home             = 1'b1;
        end else begin
          stateNext = IDLE;
        end
      end
      CLEAR: begin
        if (rowIdxReg == LAST_ROW) stateNext  = IDLE;
        else                       rowIdxNext = rowIdxPlus1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_25M) begin
    if (reset) begin
      stateReg        <= IDLE;
      rowIdxReg       <= '0;
      clearPendingReg <= 1'b0;
    end else begin
      stateReg        <= stateNext;
      rowIdxReg       <= rowIdxNext;
      clearPendingReg <= clearPendingNext;
    end
  end

  // Screen storage: the renderer needs every cell in parallel, so this is a
  // register array rather than a RAM.
  always_ff @(posedge clk_25M) begin
    if (reset) begin
      charBuffer <= {CHARS_VERT*CHARS_HORZ{ASCII_SPACE}};
    end else begin
      case (stateReg)
        IDLE:    if (accept && wrEn) charBuffer[wrRow][wrCol] <= wrData;
        SCROLL:  charBuffer[rowIdxReg] <= charBuffer[rowIdxPlus1];
        CLRROW:  charBuffer[LAST_ROW]  <= BLANK_ROW;
        CLEAR:   charBuffer[rowIdxReg] <= BLANK_ROW;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: a table of single-byte vectors with
// hand-computed cursor/cell results, then hand-written sequences for wrap,
// scroll, backspace, clear and reset corner cases.
module tb_text_console;
  import text_console_pkg::*;

  typedef struct {
    logic [7:0] ch;
    int         row;
    int         col;
    int         cr;
    int         cc;
    logic [7:0] cv;
  } vec_t;

  logic             clk_25M = 1'b0;
  logic             reset;
  charScreen_t      charBuffer;
  logic [ROW_W-1:0] cursorRow;
  logic [COL_W-1:0] cursorCol;

  int vecCount  = 0;
  int missCount = 0;

  text_console_if host();

  text_console dut (
    .clk_25M    (clk_25M),
    .reset      (reset),
    .host       (host),
    .charBuffer (charBuffer),
    .cursorRow  (cursorRow),
    .cursorCol  (cursorCol)
  );

  always #5 clk_25M = ~clk_25M;

  task automatic chk(input string name, input int act, input int exp);
    vecCount++;
    if (act != exp) begin
      missCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cursor is compared as row*100+col.
  task automatic chkCursor(input string name, input int r, input int c);
    chk(name, int'(cursorRow) * 100 + int'(cursorCol), r * 100 + c);
  endtask

  task automatic chkBuf(input string name, input charScreen_t exp);
    bit shown = 0;
    vecCount++;
    if (charBuffer !== exp) begin
      missCount++;
      for (int r = 0; r < CHARS_VERT; r++)
        for (int c = 0; c < CHARS_HORZ; c++)
          if (!shown && charBuffer[r][c] !== exp[r][c]) begin
            shown = 1;
            $display("FAIL %s: cell [%0d][%0d] got 0x%0h, expected 0x%0h",
                     name, r, c, charBuffer[r][c], exp[r][c]);
          end
    end
  endtask

  task automatic sendByte(input logic [7:0] c);
    int n = 0;
    @(negedge clk_25M);
    while (!host.charReady && n < 200) begin
      @(negedge clk_25M);
      n++;
    end
    if (!host.charReady) begin
      vecCount++;
      missCount++;
      $display("FAIL send_timeout: charReady got 0 after %0d cycles, expected 1", n);
    end
    host.charIn    = c;
    host.charValid = 1'b1;
    @(posedge clk_25M);
    #1;
    host.charValid = 1'b0;
  endtask

  task automatic sendRep(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) sendByte(c);
  endtask

  // Number of falling edges with charReady low, up to the first high one.
  task automatic busyCount(output int n);
    n = 0;
    @(negedge clk_25M);
    while (!host.charReady && n < 200) begin
      n++;
      @(negedge clk_25M);
    end
  endtask

  task automatic applyReset();
    @(negedge clk_25M);
    reset          = 1'b1;
    host.charValid = 1'b0;
    host.clearReq  = 1'b0;
    repeat (2) @(posedge clk_25M);
    @(negedge clk_25M);
    reset = 1'b0;
  endtask

  vec_t        vecs[12];
  charScreen_t blankScr, exp;
  int          busy;
  string       s;

  initial begin
    blankScr = {CHARS_VERT*CHARS_HORZ{8'h20}};
    // {byte, cursor row, cursor col, checked cell row, col, value}
    vecs[0]  = '{8'h48, 0, 1,  0, 0,  8'h48};  // 'H'
    vecs[1]  = '{8'h69, 0, 2,  0, 1,  8'h69};  // 'i'
    vecs[2]  = '{8'h0D, 0, 0,  0, 0,  8'h48};  // CR
    vecs[3]  = '{8'h0A, 1, 0,  0, 1,  8'h69};  // LF
    vecs[4]  = '{8'h07, 1, 0,  1, 0,  8'h20};  // ignored
    vecs[5]  = '{8'h7A, 1, 1,  1, 0,  8'h7A};  // 'z'
    vecs[6]  = '{8'h08, 1, 0,  1, 0,  8'h20};  // BS within row
    vecs[7]  = '{8'h08, 0, 79, 0, 79, 8'h20};  // BS to previous row
    vecs[8]  = '{8'h7E, 1, 0,  0, 79, 8'h7E};  // '~' at last col wraps
    vecs[9]  = '{8'h7F, 1, 0,  1, 0,  8'h20};  // DEL ignored
    vecs[10] = '{8'h1F, 1, 0,  0, 0,  8'h48};  // ignored
    vecs[11] = '{8'h20, 1, 1,  1, 0,  8'h20};  // space is printable

    reset          = 1'b1;
    host.charIn    = 8'h00;
    host.charValid = 1'b0;
    host.clearReq  = 1'b0;
    applyReset();
    chkBuf("reset_buf", blankScr);
    chkCursor("reset_cursor", 0, 0);
    chk("reset_ready", int'(host.charReady), 1);

    // Single-byte decode table.
    for (int i = 0; i < 12; i++) begin
      sendByte(vecs[i].ch);
      $display("vec %0d: byte 0x%0h -> cursor (%0d,%0d) cell[%0d][%0d]=0x%0h",
               i, vecs[i].ch, cursorRow, cursorCol, vecs[i].cr, vecs[i].cc,
               charBuffer[vecs[i].cr][vecs[i].cc]);
      s = $sformatf("vec%0d_cursor", i);
      chkCursor(s, vecs[i].row, vecs[i].col);
      s = $sformatf("vec%0d_cell", i);
      chk(s, int'(charBuffer[vecs[i].cr][vecs[i].cc]), int'(vecs[i].cv));
    end
    exp = blankScr;
    exp[0][0]  = 8'h48;
    exp[0][1]  = 8'h69;
    exp[0][79] = 8'h7E;
    chkBuf("table_buf", exp);

    // 81 x 'A': fills row 0, wraps, one more on row 1.
    applyReset();
    sendRep(8'h41, 81);
    exp = blankScr;
    for (int c = 0; c < CHARS_HORZ; c++) exp[0][c] = 8'h41;
    exp[1][0] = 8'h41;
    chkBuf("wrap_buf", exp);
    chkCursor("wrap_cursor", 1, 1);

    // LF at (29,5) scrolls.
    applyReset();
    sendByte(8'h61);
    sendByte(8'h0A);
    sendByte(8'h62);
    sendRep(8'h0A, 28);
    sendByte(8'h63); sendByte(8'h64); sendByte(8'h65); sendByte(8'h66); sendByte(8'h67);
    chkCursor("pre_scroll_cursor", 29, 5);
    sendByte(8'h0A);
    busyCount(busy);
    $display("scroll after LF: busy %0d cycles", busy);
    chk("scroll_busy", busy, 30);
    exp = blankScr;
    exp[0][0] = 8'h62;
    for (int c = 0; c < 5; c++) exp[28][c] = 8'h63 + 8'(c);
    chkBuf("scroll_buf", exp);
    chkCursor("scroll_cursor", 29, 0);

    // Printable at (29,79) is written, then scrolls up with its line.
    sendRep(8'h78, 79);
    sendByte(8'h51);
    busyCount(busy);
    $display("scroll after 'Q' at last cell: busy %0d cycles", busy);
    chk("scroll2_busy", busy, 30);
    exp = blankScr;
    for (int c = 0; c < 5; c++) exp[27][c] = 8'h63 + 8'(c);
    for (int c = 0; c < 79; c++) exp[28][c] = 8'h78;
    exp[28][79] = 8'h51;
    chkBuf("scroll2_buf", exp);
    chkCursor("scroll2_cursor", 29, 0);

    // Two clear pulses during a scroll collapse into one clear after it.
    sendByte(8'h0A);
    busy = 0;
    while (busy < 200) begin
      @(negedge clk_25M);
      if (host.charReady) break;
      host.clearReq = (busy == 2 || busy == 8);
      busy++;
    end
    host.clearReq = 1'b0;
    $display("scroll with pending clear: busy %0d cycles", busy);
    chk("pending_clear_busy", busy, 60);
    chkBuf("pending_clear_buf", blankScr);
    chkCursor("pending_clear_cursor", 0, 0);

    // Backspace at (0,0) and at start of row 3.
    applyReset();
    sendByte(8'h4B);
    sendByte(8'h0D);
    chk("bs00_pre", int'(charBuffer[0][0]), 8'h4B);
    sendByte(8'h08);
    chkCursor("bs00_cursor", 0, 0);
    chk("bs00_cell", int'(charBuffer[0][0]), 8'h20);
    sendRep(8'h0A, 2);
    sendRep(8'h4D, 80);
    chkCursor("bs30_pre", 3, 0);
    sendByte(8'h08);
    chkCursor("bs30_cursor", 2, 79);
    chk("bs30_cell", int'(charBuffer[2][79]), 8'h20);
    chk("bs30_neighbour", int'(charBuffer[2][78]), 8'h4D);

    // clearReq beats a simultaneous 'X'.
    @(negedge clk_25M);
    host.clearReq  = 1'b1;
    host.charIn    = 8'h58;
    host.charValid = 1'b1;
    #1;
    chk("clear_blocks_ready", int'(host.charReady), 0);
    @(posedge clk_25M);
    #1;
    host.clearReq  = 1'b0;
    host.charValid = 1'b0;
    busyCount(busy);
    $display("clear: busy %0d cycles", busy);
    chk("clear_busy", busy, 30);
    chkBuf("clear_buf", blankScr);
    chkCursor("clear_cursor", 0, 0);
    chk("clear_ready", int'(host.charReady), 1);

    // Reset in the 10th scroll cycle.
    applyReset();
    for (int i = 0; i < 29; i++) begin
      sendByte(8'h61);
      sendByte(8'h0A);
    end
    sendByte(8'h61);
    sendByte(8'h0A);
    repeat (9) @(posedge clk_25M);
    @(negedge clk_25M);
    chk("midscroll_busy", int'(host.charReady), 0);
    reset = 1'b1;
    @(posedge clk_25M);
    #1;
    $display("reset mid-scroll: ready %0d cursor (%0d,%0d)", host.charReady, cursorRow, cursorCol);
    chkBuf("midscroll_reset_buf", blankScr);
    chkCursor("midscroll_reset_cursor", 0, 0);
    chk("midscroll_reset_ready", int'(host.charReady), 1);
    @(negedge clk_25M);
    reset = 1'b0;
    sendByte(8'h5A);
    chk("post_reset_cell", int'(charBuffer[0][0]), 8'h5A);
    chkCursor("post_reset_cursor", 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
